// File: rtl/dec_tag_verify.sv
// dec_tag_verify: constant-time tag check that gates release of decrypted plaintext
module dec_tag_verify #(
   parameter int Ct_l  = 40,
   parameter int TAG_l = 128,
   parameter int CMP_W = 32,
   parameter int OUT_W = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               dec_ready,
   input  logic [(Ct_l > 0 ? Ct_l : 1)-1:0]   dec_plaintext,
   input  logic [TAG_l-1:0]                   tag_out,
   input  logic [TAG_l-1:0]                   tag_in,
   input  logic                               tag_valid,
   output logic [OUT_W-1:0]                   out_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic                               out_last,
   output logic                               auth_ok,
   output logic                               auth_fail,
   output logic                               busy
);
   localparam int PW  = Ct_l > 0 ? Ct_l : 1;
   localparam int NCH = TAG_l / CMP_W;
   localparam int NB  = Ct_l / OUT_W > 0 ? Ct_l / OUT_W : 1;
   localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
   localparam int BW  = NB > 1 ? $clog2(NB) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(NCH - 1);
   localparam logic [BW-1:0] B_LAST = BW'(NB - 1);

   typedef enum logic [2:0] {IDLE, WAIT_TAG, COMPARE, STREAM, FAIL, DONE} state_t;

   state_t           state;
   logic             dec_ready_d, tag_have, diff_acc, start, chunk_diff;
   logic [PW-1:0]    pt_buf;
   logic [TAG_l-1:0] calc_tag, rx_tag;
   logic [CW-1:0]    chunk;
   logic [BW-1:0]    beat, nbeat;
   logic [OUT_W-1:0] beat_data;

   // start edge, current chunk mismatch (chunk 0 is the MSB chunk) and the next beat to present
   always_comb begin
      start      = dec_ready & ~dec_ready_d;
      chunk_diff = |CMP_W'((calc_tag ^ rx_tag) >> (int'(C_LAST - chunk) * CMP_W));
      nbeat      = state == STREAM ? beat + 1'b1 : '0;
      beat_data  = OUT_W'({{OUT_W{1'b0}}, pt_buf} >> (int'(B_LAST - nbeat) * OUT_W));
   end

   // control FSM with registered outputs; compare always runs every chunk to keep timing fixed
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dec_ready_d <= 1'b0;
         tag_have    <= 1'b0;
         diff_acc    <= 1'b0;
         pt_buf      <= '0;
         calc_tag    <= '0;
         rx_tag      <= '0;
         chunk       <= '0;
         beat        <= '0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         auth_ok     <= 1'b0;
         auth_fail   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         dec_ready_d <= dec_ready;
         if (tag_valid && state != COMPARE && state != STREAM) begin
            rx_tag   <= tag_in;
            tag_have <= 1'b1;
         end
         case (state)
            IDLE: if (start) begin
               pt_buf   <= dec_plaintext;
               calc_tag <= tag_out;
               diff_acc <= 1'b0;
               chunk    <= '0;
               busy     <= 1'b1;
               state    <= (tag_have || tag_valid) ? COMPARE : WAIT_TAG;
            end
            WAIT_TAG: if (tag_valid) state <= COMPARE;
            COMPARE: begin
               diff_acc <= diff_acc | chunk_diff;
               chunk    <= chunk + 1'b1;
               if (chunk == C_LAST) begin
                  if (diff_acc | chunk_diff) state <= FAIL;
                  else if (Ct_l > 0) begin
                     state     <= STREAM;
                     auth_ok   <= 1'b1;
                     beat      <= '0;
                     out_valid <= 1'b1;
                     out_data  <= beat_data;
                     out_last  <= B_LAST == '0;
                  end else begin
                     state   <= DONE;
                     auth_ok <= 1'b1;
                  end
               end
            end
            STREAM: if (out_ready) begin
               if (beat == B_LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b0;
                  out_data  <= '0;
                  out_last  <= 1'b0;
               end else begin
                  beat     <= nbeat;
                  out_data <= beat_data;
                  out_last <= nbeat == B_LAST;
               end
            end
            FAIL: begin
               pt_buf    <= '0;
               calc_tag  <= '0;
               auth_fail <= 1'b1;
               state     <= DONE;
            end
            DONE: if (!dec_ready) begin
               state     <= IDLE;
               auth_ok   <= 1'b0;
               auth_fail <= 1'b0;
               tag_have  <= 1'b0;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dec_tag_verify.sv
// tb_dec_tag_verify: directed and randomized checks of tag verification and plaintext release
module tb_dec_tag_verify;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         dec_ready = 1'b0;
   logic [39:0]  dec_plaintext = '0;
   logic [127:0] tag_out = '0;
   logic [127:0] tag_in = '0;
   logic         tag_valid = 1'b0;
   logic [7:0]   out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         out_last;
   logic         auth_ok;
   logic         auth_fail;
   logic         busy;
   int           n_cmp = 0;
   int           n_err = 0;

   dec_tag_verify dut (
      .clk(clk), .rst(rst), .dec_ready(dec_ready), .dec_plaintext(dec_plaintext),
      .tag_out(tag_out), .tag_in(tag_in), .tag_valid(tag_valid), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .auth_ok(auth_ok), .auth_fail(auth_fail), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: tag 3 cycles early, 1: tag with start, 2: tag 'late' cycles after start
   task automatic run_msg(input logic [39:0] pt, input logic [127:0] calc, input logic [127:0] rx,
                          input int mode, input int late, input int pct,
                          input logic [15:0] pat, input int plen);
      logic [7:0] exp_q[$];
      bit ok, r;
      int k, cyc;
      ok = (calc == rx);
      for (int i = 4; i >= 0; i--) exp_q.push_back(8'(pt >> (8 * i)));
      out_ready = 1'b0;
      if (mode == 0) begin
         tag_in = rx; tag_valid = 1'b1; tick(); tag_valid = 1'b0; tick(); tick();
      end
      dec_plaintext = pt; tag_out = calc; dec_ready = 1'b1;
      if (mode == 1) begin
         tag_in = rx; tag_valid = 1'b1;
      end
      tick();
      tag_valid = 1'b0;
      chk("busy_start", busy, 1);
      if (mode == 2) begin
         for (int i = 0; i < late; i++) begin
            tick();
            chk("wait_tag", {busy, out_valid, auth_ok, auth_fail}, 4'b1000);
         end
         tag_in = rx; tag_valid = 1'b1; tick(); tag_valid = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("compare", {out_valid, auth_ok, auth_fail}, 3'b000);
      end
      tick();
      if (ok) begin
         chk("first_valid", {out_valid, auth_ok, auth_fail}, 3'b110);
         k = 0; cyc = 0;
         while (k < 5 && cyc < 200) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_data", out_data, exp_q[k]);
            chk("beat_last", out_last, k == 4);
            r = (cyc < plen) ? pat[cyc] : ($urandom_range(99) < pct);
            out_ready = r;
            tick();
            cyc++;
            if (r) k++;
         end
         chk("stream_done", k, 5);
         out_ready = 1'b0;
         chk("after_stream", {auth_ok, auth_fail, busy, out_valid, out_last, out_data}, 13'h1400);
      end else begin
         chk("fail_state", {out_valid, auth_ok, auth_fail}, 3'b000);
         tick();
         chk("fail_flag", {out_valid, auth_ok, auth_fail}, 3'b001);
         chk("pt_wiped", dut.pt_buf, 0);
      end
      for (int i = 0; i < 2; i++) begin
         out_ready = 1'($urandom_range(1));
         tick();
         chk("done_hold", {out_valid, auth_ok, auth_fail, busy}, {1'b0, ok, !ok, 1'b1});
      end
      out_ready = 1'b0;
      dec_ready = 1'b0;
      tick();
      chk("done_exit", {auth_ok, auth_fail, busy, out_valid}, 0);
   endtask

   initial begin
      logic [127:0] t, calc, rx;
      logic [39:0]  pt;
      t = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      tick(); tick();
      rst = 1'b0;
      chk("reset", {out_valid, out_last, auth_ok, auth_fail, busy, out_data}, 0);
      run_msg(40'h0102030405, t, t, 0, 0, 100, 16'h0, 0);
      run_msg(40'h0102030405, t, t ^ 128'd1, 0, 0, 100, 16'h0, 0);
      run_msg(40'h0102030405, t, t, 0, 0, 100, 16'h01B4, 9);
      run_msg(40'h0102030405, t, t, 2, 10, 100, 16'h0, 0);
      run_msg(40'h0102030405, t, t, 1, 0, 100, 16'h0, 0);
      dec_plaintext = 40'h0102030405; tag_out = t; tag_in = t;
      dec_ready = 1'b1; tag_valid = 1'b1; out_ready = 1'b1;
      tick();
      tag_valid = 1'b0;
      repeat (4) tick();
      chk("rst_beat1", out_data, 8'h01);
      tick();
      chk("rst_beat2", out_data, 8'h02);
      tick();
      rst = 1'b1; dec_ready = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_mid", {out_valid, out_last, auth_ok, auth_fail, busy, out_data}, 0);
      out_ready = 1'b1;
      tick();
      chk("rst_quiet", {out_valid, busy, auth_ok}, 0);
      run_msg(40'h0102030405, t, t, 1, 0, 100, 16'h0, 0);
      for (int m = 0; m < 8; m++) begin
         pt = 40'({$urandom(), $urandom()});
         calc = {$urandom(), $urandom(), $urandom(), $urandom()};
         rx = calc;
         if ($urandom_range(1) == 1) rx[$urandom_range(127)] ^= 1'b1;
         run_msg(pt, calc, rx, $urandom_range(2), $urandom_range(6, 1), $urandom_range(100, 30), 16'h0, 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
